// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the multi-channel event scoreboard.
package scoreboard_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scoreboard_multi_if.sv
// Counting inputs and readout handshake of the multi-channel scoreboard.
interface scoreboard_multi_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned EVT_W  = 8,
  parameter int unsigned DATA_W = 24
) ();
  import scoreboard_pkg::*;

  localparam int unsigned CH_W = ch_width(N_CH);

  logic              i_valid;
  logic [N_CH-1:0]   i_event;
  logic              i_snap;
  logic              i_ready;
  logic              o_busy;
  logic              o_valid;
  logic [CH_W-1:0]   o_ch;
  logic [EVT_W-1:0]  o_count;
  logic              o_ovf;
  logic              o_last;
  logic [DATA_W-1:0] o_data_count;
  logic              o_data_ovf;

  modport master (
    output i_valid, i_event, i_snap, i_ready,
    input  o_busy, o_valid, o_ch, o_count, o_ovf, o_last, o_data_count, o_data_ovf
  );

  modport slave (
    input  i_valid, i_event, i_snap, i_ready,
    output o_busy, o_valid, o_ch, o_count, o_ovf, o_last, o_data_count, o_data_ovf
  );

endinterface

// File: rtl/sb_counter.sv
// One live counter with sticky overflow; exposes its post-increment value so
// the owner can capture it on the same edge that clears it.
module sb_counter
  import scoreboard_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] next_count_c,
  output logic         next_ovf_c
);

  logic [W-1:0] count;
  logic         ovf;

  always_comb begin
    next_count_c = count;
    next_ovf_c   = ovf;
    if (inc) begin
      if (count == {W{1'b1}}) begin
        next_ovf_c   = 1'b1;
        next_count_c = (SATURATE == MODE_SAT) ? count : '0;
      end else begin
        next_count_c = count + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= next_count_c;
      ovf   <= next_ovf_c;
    end
  end

endmodule

// File: rtl/scoreboard_multi.sv
// Multi-channel event/data-beat scoreboard with atomic snapshot and
// per-channel valid/ready readout of the captured window.
module scoreboard_multi
  import scoreboard_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned EVT_W    = 8,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input logic               clk,
  input logic               reset,
  scoreboard_multi_if.slave bus
);

  localparam int unsigned CH_W = ch_width(N_CH);

  state_t                       state;
  logic                         snap_acc_c;
  logic [N_CH-1:0][EVT_W-1:0]   evt_nxt_c;
  logic [N_CH-1:0]              evt_ovf_nxt_c;
  logic [DATA_W-1:0]            data_nxt_c;
  logic                         data_ovf_nxt_c;
  logic [N_CH-1:0][EVT_W-1:0]   cap_cnt;
  logic [N_CH-1:0]              cap_ovf;
  logic [CH_W-1:0]              ch_nxt_c;

  assign snap_acc_c = bus.i_snap && (state == ST_IDLE);
  assign ch_nxt_c   = bus.o_ch + CH_W'(1);

  for (genvar k = 0; k < N_CH; k++) begin : g_evt
    sb_counter #(.W(EVT_W), .SATURATE(SATURATE)) u_evt (
      .clk          (clk),
      .reset        (reset),
      .inc          (bus.i_valid & bus.i_event[k]),
      .clr          (snap_acc_c),
      .next_count_c (evt_nxt_c[k]),
      .next_ovf_c   (evt_ovf_nxt_c[k])
    );
  end

  sb_counter #(.W(DATA_W), .SATURATE(SATURATE)) u_data (
    .clk          (clk),
    .reset        (reset),
    .inc          (bus.i_valid),
    .clr          (snap_acc_c),
    .next_count_c (data_nxt_c),
    .next_ovf_c   (data_ovf_nxt_c)
  );

  // Capture on snapshot, then present one captured channel per accepted beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= ST_IDLE;
      cap_cnt          <= '0;
      cap_ovf          <= '0;
      bus.o_busy       <= 1'b0;
      bus.o_valid      <= 1'b0;
      bus.o_ch         <= '0;
      bus.o_count      <= '0;
      bus.o_ovf        <= 1'b0;
      bus.o_last       <= 1'b0;
      bus.o_data_count <= '0;
      bus.o_data_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (snap_acc_c) begin
            state            <= ST_STREAM;
            cap_cnt          <= evt_nxt_c;
            cap_ovf          <= evt_ovf_nxt_c;
            bus.o_data_count <= data_nxt_c;
            bus.o_data_ovf   <= data_ovf_nxt_c;
            bus.o_ch         <= '0;
            bus.o_count      <= evt_nxt_c[0];
            bus.o_ovf        <= evt_ovf_nxt_c[0];
            bus.o_last       <= (N_CH == 1);
            bus.o_valid      <= 1'b1;
            bus.o_busy       <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (bus.i_ready) begin
            if (bus.o_last) begin
              state       <= ST_IDLE;
              bus.o_valid <= 1'b0;
              bus.o_busy  <= 1'b0;
              bus.o_ch    <= '0;
              bus.o_last  <= 1'b0;
            end else begin
              bus.o_ch    <= ch_nxt_c;
              bus.o_count <= cap_cnt[ch_nxt_c];
              bus.o_ovf   <= cap_ovf[ch_nxt_c];
              bus.o_last  <= (ch_nxt_c == CH_W'(N_CH - 1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard_multi.sv
// Three scoreboard configurations driven in lockstep and checked against a
// raw-count reference model through an expected-beat queue.
module tb_scoreboard_multi;

  localparam int unsigned N_CH = 4;

  typedef struct packed {
    logic [1:0]  ch;
    logic        last;
    logic [7:0]  c8;
    logic        o8;
    logic [3:0]  cw;
    logic        ow;
    logic [3:0]  cs;
    logic        os;
    logic [23:0] d24;
    logic        dv24;
    logic [4:0]  dw;
    logic        dvw;
    logic [4:0]  ds;
    logic        dvs;
  } beat_t;

  logic            clk;
  logic            reset;
  logic            drv_valid;
  logic [N_CH-1:0] drv_event;
  logic            drv_snap;
  logic            drv_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  scoreboard_multi_if #(.N_CH(N_CH), .EVT_W(8), .DATA_W(24)) if0 ();
  scoreboard_multi_if #(.N_CH(N_CH), .EVT_W(4), .DATA_W(5))  if1 ();
  scoreboard_multi_if #(.N_CH(N_CH), .EVT_W(4), .DATA_W(5))  if2 ();

  assign if0.i_valid = drv_valid;
  assign if0.i_event = drv_event;
  assign if0.i_snap  = drv_snap;
  assign if0.i_ready = drv_ready;
  assign if1.i_valid = drv_valid;
  assign if1.i_event = drv_event;
  assign if1.i_snap  = drv_snap;
  assign if1.i_ready = drv_ready;
  assign if2.i_valid = drv_valid;
  assign if2.i_event = drv_event;
  assign if2.i_snap  = drv_snap;
  assign if2.i_ready = drv_ready;

  scoreboard_multi #(.N_CH(N_CH), .EVT_W(8), .DATA_W(24), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  scoreboard_multi #(.N_CH(N_CH), .EVT_W(4), .DATA_W(5), .SATURATE(0)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));
  scoreboard_multi #(.N_CH(N_CH), .EVT_W(4), .DATA_W(5), .SATURATE(1)) dut2 (
    .clk(clk), .reset(reset), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: unbounded raw counts, converted per configuration at capture.
  int    m_evt [N_CH];
  int    m_data;
  bit    m_busy;
  int    m_ch;
  beat_t expq[$];

  function automatic beat_t mk_beat(input int ch, input int ev, input int d);
    beat_t b;
    b.ch   = 2'(ch);
    b.last = (ch == N_CH - 1);
    b.c8   = 8'(ev % 256);
    b.o8   = (ev >= 256);
    b.cw   = 4'(ev % 16);
    b.ow   = (ev >= 16);
    b.cs   = (ev >= 16) ? 4'hf : 4'(ev);
    b.os   = (ev >= 16);
    b.d24  = 24'(d);
    b.dv24 = (d >= (1 << 24));
    b.dw   = 5'(d % 32);
    b.dvw  = (d >= 32);
    b.ds   = (d >= 32) ? 5'h1f : 5'(d);
    b.dvs  = (d >= 32);
    return b;
  endfunction

  always @(posedge clk) begin
    bit old_busy;
    if (!reset) begin
      m_busy = 1'b0;
      m_ch   = 0;
      m_data = 0;
      foreach (m_evt[k]) m_evt[k] = 0;
      expq.delete();
    end else begin
      old_busy = m_busy;
      if (drv_valid) begin
        m_data++;
        for (int k = 0; k < N_CH; k++) if (drv_event[k]) m_evt[k]++;
      end
      if (old_busy && drv_ready) begin
        if (m_ch == N_CH - 1) begin
          m_busy = 1'b0;
          m_ch   = 0;
        end else begin
          m_ch++;
        end
      end
      if (drv_snap && !old_busy) begin
        for (int k = 0; k < N_CH; k++) begin
          expq.push_back(mk_beat(k, m_evt[k], m_data));
          m_evt[k] = 0;
        end
        m_data = 0;
        m_busy = 1'b1;
        m_ch   = 0;
      end
    end
  end

  function automatic beat_t sample();
    beat_t o;
    o.ch   = if0.o_ch;
    o.last = if0.o_last;
    o.c8   = if0.o_count;
    o.o8   = if0.o_ovf;
    o.cw   = if1.o_count;
    o.ow   = if1.o_ovf;
    o.cs   = if2.o_count;
    o.os   = if2.o_ovf;
    o.d24  = if0.o_data_count;
    o.dv24 = if0.o_data_ovf;
    o.dw   = if1.o_data_count;
    o.dvw  = if1.o_data_ovf;
    o.ds   = if2.o_data_count;
    o.dvs  = if2.o_data_ovf;
    return o;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    drv_valid = 1'b0;
    drv_event = '0;
    drv_snap  = 1'b0;
  endtask

  // Waits (bounded) for a valid beat, pairs it with the next expected beat,
  // and lets it be accepted on the following edge.
  task automatic get_beat(output beat_t e, output beat_t o, output bit ok);
    ok = 1'b0;
    e  = '0;
    o  = '0;
    for (int i = 0; i < 20; i++) begin
      if (if0.o_valid) begin
        o = sample();
        if (expq.size() > 0) begin
          e  = expq.pop_front();
          ok = 1'b1;
        end
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
  endtask

  task automatic do_snap();
    drv_snap = 1'b1;
    tick(1);
    drv_snap = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    reset = 1'b0;
    idle_inputs();
    drv_ready = 1'b1;
    tick(3);
    obs = {if0.o_valid, if0.o_busy, if0.o_last, if0.o_ch, if0.o_data_count, if0.o_data_ovf,
           if1.o_valid, if2.o_valid};
    tests_run++;
    if (obs !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", obs, 32'h0);
    end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    beat_t e, o;
    bit    ok;
    drv_valid = 1'b1;
    drv_event = 4'b0101;
    tick(10);
    drv_event = 4'b0000;
    do_snap();
    drv_valid = 1'b0;
    tests_run++;
    if (if0.o_valid !== 1'b1 || if0.o_busy !== 1'b1 || if0.o_ch !== 2'd0) begin
      tests_failed++;
      $display("FAIL basic_latency: valid=%b busy=%b ch=%0d expected 1 1 0",
               if0.o_valid, if0.o_busy, if0.o_ch);
    end
    for (int i = 0; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        tests_failed++;
        $display("FAIL basic_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
    tests_run++;
    if (if0.o_valid !== 1'b0 || if0.o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_end: valid=%b busy=%b expected 0 0", if0.o_valid, if0.o_busy);
    end
  endtask

  task automatic test_overflow();
    beat_t e, o;
    bit    ok;
    // 17 events: wraps the 4-bit counters, saturates the other
    drv_valid = 1'b1;
    drv_event = 4'b0010;
    tick(17);
    idle_inputs();
    do_snap();
    for (int i = 0; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        tests_failed++;
        $display("FAIL ovf17_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
    // 40 data beats and 20 events: data counters overflow too
    drv_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drv_event = (i < 20) ? 4'b0010 : 4'b0000;
      tick(1);
    end
    idle_inputs();
    do_snap();
    for (int i = 0; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        tests_failed++;
        $display("FAIL ovf20_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
    // Quiet window: counts and sticky flags must have been cleared
    tick(2);
    do_snap();
    for (int i = 0; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e || o.cs !== 4'h0 || o.os !== 1'b0) begin
        tests_failed++;
        $display("FAIL ovf_clear_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
  endtask

  task automatic test_stall();
    beat_t e, o, held;
    bit    ok;
    drv_valid = 1'b1;
    drv_event = 4'b0110;
    tick(3);
    drv_event = 4'b0000;
    do_snap();
    drv_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        tests_failed++;
        $display("FAIL stall_pre_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
    drv_ready = 1'b0;
    held = (expq.size() > 0) ? expq[0] : '0;
    for (int i = 0; i < 5; i++) begin
      o = sample();
      tests_run++;
      if (o !== held || if0.o_valid !== 1'b1 || o.ch !== 2'd2) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got %h valid=%b expected %h valid=1", i, o, if0.o_valid, held);
      end
      if (i == 1) begin
        drv_snap  = 1'b1;
        drv_valid = 1'b1;
        drv_event = 4'b0001;
      end
      tick(1);
      idle_inputs();
    end
    drv_ready = 1'b1;
    for (int i = 2; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        tests_failed++;
        $display("FAIL stall_post_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
    // The ignored snap left the live window intact: ch0=1, data=1
    do_snap();
    for (int i = 0; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e || (i == 0 && o.c8 !== 8'd1)) begin
        tests_failed++;
        $display("FAIL stall_window_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
  endtask

  task automatic test_no_valid();
    beat_t e, o;
    bit    ok;
    drv_valid = 1'b0;
    drv_event = 4'b1111;
    tick(8);
    drv_event = 4'b0000;
    do_snap();
    for (int i = 0; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e || o.c8 !== 8'd0 || o.d24 !== 24'd0) begin
        tests_failed++;
        $display("FAIL novalid_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    bit    ok;
    drv_valid = 1'b1;
    drv_event = 4'b1000;
    drv_snap  = 1'b1;
    tick(1);
    // snap held high through the stream; only the idle cycle after it counts
    for (int i = 0; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        tests_failed++;
        $display("FAIL b2b_first_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
    tests_run++;
    if (if0.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle_gap: valid=%b expected 0", if0.o_valid);
    end
    tick(1);
    idle_inputs();
    tests_run++;
    if (if0.o_valid !== 1'b1 || if0.o_ch !== 2'd0) begin
      tests_failed++;
      $display("FAIL b2b_restart: valid=%b ch=%0d expected 1 0", if0.o_valid, if0.o_ch);
    end
    for (int i = 0; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        tests_failed++;
        $display("FAIL b2b_second_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_t e, o;
    bit    ok;
    drv_valid = 1'b1;
    drv_event = 4'b1111;
    tick(2);
    drv_event = 4'b0000;
    do_snap();
    drv_valid = 1'b0;
    get_beat(e, o, ok);
    tests_run++;
    if (!ok || o !== e) begin
      tests_failed++;
      $display("FAIL mid_beat0: got %h expected %h ok=%0d", o, e, ok);
    end
    reset = 1'b0;
    tick(1);
    tests_run++;
    if ({if0.o_valid, if0.o_busy, if1.o_valid, if2.o_busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_abort: valid/busy=%b expected 0000",
               {if0.o_valid, if0.o_busy, if1.o_valid, if2.o_busy});
    end
    reset = 1'b1;
    do_snap();
    for (int i = 0; i < N_CH; i++) begin
      get_beat(e, o, ok);
      tests_run++;
      if (!ok || o !== e || o.c8 !== 8'd0) begin
        tests_failed++;
        $display("FAIL mid_fresh_beat%0d: got %h expected %h ok=%0d", i, o, e, ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_no_valid();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/scoreboard_multi.md
Name: scoreboard_multi

Overview:
Multi-channel successor to the single-channel event scoreboard, sitting beside the arithmetic DUT in the testbench.
- Counts events on N_CH independent channels and counts qualified data beats, each with a configurable counter width.
- Overflow is handled per a selectable wrap or saturate mode.
- On a snapshot request it atomically captures all counters and restarts the window, then streams the captured results out one channel per beat over a valid/ready handshake.

Parameters:
N_CH, 4, number of event channels (1..16)
EVT_W, 8, width of each event counter
DATA_W, 24, width of data-beat counter
SATURATE, 0, 0 = counters wrap modulo 2^W; 1 = counters hold at all-ones

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
i_valid  in  1  data beat qualifier; data counter increments when high
i_event  in  N_CH  per-channel event strobe, counted only when i_valid=1
i_snap  in  1  single-cycle snapshot request
o_busy  out  1  high while captured results are streaming
o_valid  out  1  readout beat valid
i_ready  in  1  readout beat accepted when o_valid & i_ready
o_ch  out  max(1,clog2(N_CH))  channel index of current beat
o_count  out  EVT_W  captured event count for o_ch
o_ovf  out  1  captured sticky overflow flag for o_ch
o_last  out  1  high on beat for channel N_CH-1
o_data_count  out  DATA_W  captured data-beat count, stable while o_busy=1
o_data_ovf  out  1  captured data-counter overflow flag

Behaviour:
Reset (reset=0 at a clk edge):
- All live counters, overflow flags, captured registers, o_ch, o_data_count and o_data_ovf go to 0.
- o_valid, o_busy and o_last go to 0; FSM goes to IDLE.
- Reset mid-stream aborts the stream immediately with no further beats.

Counting, every cycle:
- i_valid=1: live data counter +1. Live event counter k +1 where i_event[k]=1.
- i_valid=0: event strobes are ignored.

Overflow:
- An increment from all-ones sets that counter's sticky ovf flag.
- SATURATE=0: the counter wraps to 0. SATURATE=1: it holds at all-ones.
- Flags stay set until the next accepted snapshot.

Snapshot, accepted only when i_snap=1 and FSM is IDLE:
- Same edge: live values, including the current cycle's increment, go into the captured registers.
- Same edge: live counters and flags clear to 0.
- Next cycle: FSM enters STREAM with o_valid=1, o_ch=0.
- A snapshot requested while busy is ignored: counting continues and no state changes.
- i_snap with i_event on the same cycle: that event is included in the captured value, not the new window.

FSM IDLE -> STREAM -> IDLE:
- STREAM: o_busy=1, o_valid=1. Outputs reflect captured[o_ch].
- On o_valid & i_ready with o_ch < N_CH-1: o_ch +1.
- On acceptance with o_last=1: return to IDLE next cycle; o_valid=0, o_busy=0, o_ch=0.
- i_ready low stalls; o_ch, o_count, o_ovf and o_last stay stable.
- o_valid never deasserts before acceptance.
- Live counting continues throughout STREAM.

Latency:
- Snapshot to first beat: 1 cycle.
- Minimum stream length: N_CH cycles.
- Earliest next accepted snapshot: the cycle after return to IDLE.

Widths:
- Counters use exactly EVT_W / DATA_W bits; no carry-out is exposed except through the ovf flags.
- When N_CH=1, o_ch is 1 bit and always 0.

Decomposition:
- Package scoreboard_pkg holds:
  - FSM state enum (ST_IDLE, ST_STREAM);
  - mode constants MODE_WRAP=0, MODE_SAT=1;
  - a clog2-based helper constant function for the o_ch width.
- Sub-module sb_counter(W, SATURATE): one counter plus sticky ovf flag, with inputs inc and clr (clr has priority but still loads the captured value first at the top level).
- Instantiate N_CH+1 times: event channels and the data counter.
- Capture registers and the readout FSM stay in scoreboard_multi.

Test Plan:
1. Reset, N_CH=4, EVT_W=8: i_valid=1 for 10 cycles, i_event=4'b0101 for all 10, then i_snap with i_ready=1 -> beats ch0=10, ch1=0, ch2=10, ch3=0, o_last on ch3, o_data_count=11 (snap cycle counted).
2. SATURATE=0, EVT_W=4: 17 events on ch1, snap -> ch1 count=1, o_ovf=1; others count=0, o_ovf=0.
3. SATURATE=1, EVT_W=4: 20 events on ch1, snap -> ch1 count=15, o_ovf=1; second snap with no events -> count=0, o_ovf=0.
4. i_ready held low 5 cycles during ch2 beat, while i_snap is pulsed -> o_ch=2 and o_count stable, snap ignored, live counters not cleared.
5. i_valid=0 with i_event=4'b1111 for 8 cycles, then snap -> all counts 0, o_data_count=0.
6. Reset asserted mid-stream at ch1 -> next cycle o_valid=0, o_busy=0; a fresh snap streams all zeros.
